vec_instr_issuer: RTL and testbench

- Host-side initiator for the vector processor's 13-bit instruction port.
- Buffers a queued program of instructions and processor-reset commands.
- Drives each entry onto the processor for an opcode-dependent number of cycles. This replaces hand-timed instruction driving.
- Sits between a host/loader and the Processor instance. Owns the processor's instruction bus and its active-high reset line.

---
 rtl/vec_proc_pkg.sv | 20 ++
 rtl/vec_instr_fifo.sv | 53 +++++
 rtl/vec_instr_issuer.sv | 161 ++++++++++++++++
 tb/tb_vec_instr_issuer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vec_proc_pkg.sv
// Shared constants and types for the vector processor instruction issuer.
package vec_proc_pkg;

    localparam int unsigned INSTR_W = 13;
    localparam int unsigned ADDR_W  = 9;
    localparam int unsigned REG_W   = 2;
    localparam int unsigned ENTRY_W = INSTR_W + 1;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RSTP
    } issuer_state_e;

endpackage

// File: rtl/vec_instr_fifo.sv
// Synchronous program FIFO for the issuer; pointers carry an extra wrap bit to tell full from empty.
module vec_instr_fifo
    import vec_proc_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         wdata,
    input  logic                       pop,
    output logic [ENTRY_W-1:0]         rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               push_ok, pop_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rdata   = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/vec_instr_issuer.sv
// Queues host instructions/reset commands and drives each onto the processor for its hold time.
// Optional per-type pop counters are enabled with VEC_ISSUER_STATS_EN.
module vec_instr_issuer
    import vec_proc_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned LOAD_CYCLES  = 10,
    parameter int unsigned STORE_CYCLES = 10,
    parameter int unsigned ADD_CYCLES   = 10,
    parameter int unsigned MUL_CYCLES   = 10,
    parameter int unsigned RST_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [ENTRY_W-1:0]         wr_data,
    input  logic                       run_en,
    output logic [INSTR_W-1:0]         proc_instr,
    output logic                       proc_rst,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef VEC_ISSUER_STATS_EN
    ,
    output logic [15:0]                stat_load,
    output logic [15:0]                stat_store,
    output logic [15:0]                stat_add,
    output logic [15:0]                stat_mul,
    output logic [15:0]                stat_rst
`endif
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CYC = max2(max2(max2(LOAD_CYCLES, STORE_CYCLES),
                                                max2(ADD_CYCLES, MUL_CYCLES)), RST_CYCLES);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    if (LOAD_CYCLES < 1 || STORE_CYCLES < 1 || ADD_CYCLES < 1 || MUL_CYCLES < 1 ||
        RST_CYCLES < 1) begin : gen_bad_cycles
        $error("vec_instr_issuer: every *_CYCLES parameter must be at least 1");
    end

    function automatic logic [CNT_W-1:0] hold_last(input logic [1:0] op);
        logic [CNT_W-1:0] n;
        n = CNT_W'(LOAD_CYCLES - 1);
        unique case (op)
            OP_LOAD:  n = CNT_W'(LOAD_CYCLES - 1);
            OP_STORE: n = CNT_W'(STORE_CYCLES - 1);
            OP_ADD:   n = CNT_W'(ADD_CYCLES - 1);
            OP_MUL:   n = CNT_W'(MUL_CYCLES - 1);
        endcase
        return n;
    endfunction

    issuer_state_e        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic                 done_q, done_d;
    logic                 pop;
    logic                 entry_done;
    logic                 fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [1:0]           op;

    vec_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_valid),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_ready   = !fifo_full;
    assign op         = fifo_rdata[INSTR_W-1 -: 2];
    assign entry_done = (state_q != IDLE) && (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            done_q  <= done_d;
        end
    end

    // A finishing entry hands over to the next one on the same edge, so no gap cycle appears.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        pop     = 1'b0;
        done_d  = entry_done && fifo_empty;
        if (state_q != IDLE && cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (state_q == IDLE || entry_done) begin
            if (run_en && !fifo_empty) begin
                pop = 1'b1;
                if (fifo_rdata[ENTRY_W-1]) begin
                    state_d = RSTP;
                    cnt_d   = CNT_W'(RST_CYCLES - 1);
                end else begin
                    state_d = HOLD;
                    cnt_d   = hold_last(op);
                    // ALU ops carry no operands; keep the reg/addr lanes quiet.
                    instr_d = op[1] ? {op, {(INSTR_W - 2){1'b0}}} : fifo_rdata[INSTR_W-1:0];
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        proc_rst   = (state_q == RSTP);
        proc_instr = instr_q;
        done       = done_q;
    end

`ifdef VEC_ISSUER_STATS_EN
    logic [15:0] stat_q [5];
    logic [15:0] stat_d [5];
    logic [2:0]  stat_idx;

    assign stat_idx = fifo_rdata[ENTRY_W-1] ? 3'd4 : {1'b0, op};

    always_comb begin
        stat_d = stat_q;
        if (pop && stat_q[stat_idx] != 16'hFFFF) stat_d[stat_idx] = stat_q[stat_idx] + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) stat_q[i] <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_load  = stat_q[0];
    assign stat_store = stat_q[1];
    assign stat_add   = stat_q[2];
    assign stat_mul   = stat_q[3];
    assign stat_rst   = stat_q[4];
`endif

endmodule

// File: tb/tb_vec_instr_issuer.sv
// Scoreboard bench for vec_instr_issuer: stimulus queues per-cycle expectations, a monitor checks them.
module tb_vec_instr_issuer;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        prst;
        logic [12:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [13:0] wr_data = '0;
    logic        run_en = 1'b0;
    logic [12:0] proc_instr;
    logic        proc_rst;
    logic        busy;
    logic        done;
    logic [4:0]  fifo_count;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   armed = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    vec_instr_issuer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .run_en     (run_en),
        .proc_instr (proc_instr),
        .proc_rst   (proc_rst),
        .busy       (busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    // Once an entry starts, every following cycle must match until a done or the queue runs dry.
    always @(negedge clk) begin
        if (rst && (busy || done || armed)) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output busy=%0b done=%0b rst=%0b instr=%h",
                         busy, done, proc_rst, proc_instr);
                armed = 1'b0;
            end else begin
                mon_e = exp_q.pop_front();
                if ({busy, done, proc_rst, proc_instr} !== mon_e) begin
                    bad++;
                    $display("FAIL stream got busy=%0b done=%0b rst=%0b instr=%h want busy=%0b done=%0b rst=%0b instr=%h",
                             busy, done, proc_rst, proc_instr,
                             mon_e.busy, mon_e.done, mon_e.prst, mon_e.instr);
                end
                armed = !mon_e.done && (exp_q.size() != 0);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    task automatic exp_hold(input logic [12:0] instr, input int n, input logic prst);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.busy  = 1'b1;
            e.done  = 1'b0;
            e.prst  = prst;
            e.instr = instr;
            exp_q.push_back(e);
        end
    endtask

    task automatic exp_done(input logic [12:0] instr);
        exp_t e;
        e.busy  = 1'b0;
        e.done  = 1'b1;
        e.prst  = 1'b0;
        e.instr = instr;
        exp_q.push_back(e);
    endtask

    task automatic push(input logic [13:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [13:0] d;
        logic [12:0] last_instr;

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_proc_instr", proc_instr, 13'h0);
        chk("rst_proc_rst", proc_rst, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);

        // Single load, 10-cycle hold then done.
        run_en = 1'b1;
        exp_hold(13'h0014, 10, 1'b0);
        exp_done(13'h0014);
        push(14'h0014);
        drain("t1_drained", 40);

        // Back-to-back load, mul, add, reset.
        exp_hold(13'h0415, 10, 1'b0);
        push(14'h0415);
        exp_hold(13'h1800, 10, 1'b0);
        push(14'h1A33);
        exp_hold(13'h1000, 10, 1'b0);
        push(14'h1155);
        exp_hold(13'h1000, 1, 1'b1);
        push(14'h2000);
        exp_done(13'h1000);
        drain("t2_drained", 80);

        // Fill to capacity while halted, then release.
        @(negedge clk);
        run_en = 1'b0;
        last_instr = '0;
        for (int i = 0; i < 16; i++) begin
            d = {1'b0, (i % 2 == 1) ? 2'b01 : 2'b00, 2'(i), 9'(i * 7 + 1)};
            exp_hold(d[12:0], 10, 1'b0);
            last_instr = d[12:0];
            push(d);
        end
        chk("full_wr_ready", wr_ready, 0);
        chk("full_count", fifo_count, 16);
        push(14'h0FFF);
        chk("full_reject_count", fifo_count, 16);
        chk("full_reject_ready", wr_ready, 0);
        exp_done(last_instr);
        run_en = 1'b1;
        @(negedge clk);
        chk("full_pop_ready", wr_ready, 1);
        chk("full_pop_count", fifo_count, 15);
        drain("t3_drained", 250);

        // run_en dropped in 4th cycle of a store hold.
        @(negedge clk);
        run_en = 1'b0;
        exp_hold(13'h0A21, 10, 1'b0);
        push(14'h0A21);
        push(14'h0123);
        run_en = 1'b1;
        repeat (4) @(negedge clk);
        run_en = 1'b0;
        drain("t4_store_drained", 30);
        repeat (3) @(negedge clk);
        #1;
        chk("t4_idle_busy", busy, 0);
        chk("t4_idle_count", fifo_count, 1);
        chk("t4_idle_instr", proc_instr, 13'h0A21);
        exp_hold(13'h0123, 10, 1'b0);
        exp_done(13'h0123);
        run_en = 1'b1;
        @(negedge clk);
        #1;
        chk("t4_resume_busy", busy, 1);
        chk("t4_resume_instr", proc_instr, 13'h0123);
        drain("t4_drained", 30);

        // Async reset during cycle 5 of a multiply with three entries behind it.
        @(negedge clk);
        run_en = 1'b0;
        exp_hold(13'h1800, 5, 1'b0);
        push(14'h1800);
        push(14'h0001);
        push(14'h0002);
        push(14'h0003);
        chk("t5_count_before", fifo_count, 4);
        run_en = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_rst_instr", proc_instr, 13'h0);
        chk("t5_rst_prst", proc_rst, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_count", fifo_count, 0);
        chk("t5_rst_ready", wr_ready, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        chk("t5_after_count", fifo_count, 0);
        chk("t5_after_busy", busy, 0);
        chk("t5_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
